// File: rtl/pmem_arb_pkg.sv
// Shared types for the I/D-cache physical-memory arbiter.
// The offset width sets the line alignment applied to downstream addresses.
package pmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

    localparam int OFFSET_BITS = 5;

endpackage

// File: rtl/pmem_arbiter.sv
// Shares one downstream line port between the I-cache and D-cache, one whole
// transaction at a time; the winner's request is latched until pmem_resp.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_BITS) - 1);

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return a & ~OFFSET_MASK;
    endfunction

    arb_state_t        r_state, w_state_next;
    grant_t            r_last_grant, w_last_grant_next;
    logic              r_pmem_read, w_read_next;
    logic              r_pmem_write, w_write_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [LINE_W-1:0] r_wdata, w_wdata_next;
    logic              w_i_req, w_d_req;
    logic              w_i_resp, w_d_resp;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_I;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_read_next       = 1'b0;
        w_write_next      = 1'b0;
        w_addr_next       = r_addr;
        w_wdata_next      = r_wdata;
        w_i_resp          = 1'b0;
        w_d_resp          = 1'b0;
        unique case (r_state)
            IDLE: begin
                // On a tie the side that did not win last time gets the port.
                if (w_i_req && (!w_d_req || r_last_grant == GNT_D)) begin
                    w_state_next      = SERVE_I;
                    w_last_grant_next = GNT_I;
                    w_read_next       = 1'b1;
                    w_addr_next       = line_align(i_pmem_address);
                    w_wdata_next      = '0;
                end else if (w_d_req) begin
                    // Read and write together is illegal; write takes precedence.
                    w_state_next      = SERVE_D;
                    w_last_grant_next = GNT_D;
                    w_write_next      = d_pmem_write;
                    w_read_next       = ~d_pmem_write;
                    w_addr_next       = line_align(d_pmem_address);
                    w_wdata_next      = d_pmem_wdata;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    w_i_resp     = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_read_next  = r_pmem_read;
                    w_write_next = r_pmem_write;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    w_d_resp     = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_read_next  = r_pmem_read;
                    w_write_next = r_pmem_write;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Downstream port is fully registered; requester inputs never reach it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_pmem_read  <= w_read_next;
            r_pmem_write <= w_write_next;
            r_addr       <= w_addr_next;
            r_wdata      <= w_wdata_next;
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign i_pmem_resp  = w_i_resp;
    assign d_pmem_resp  = w_d_resp;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    a_no_d_rd_wr: assert property (@(posedge clk) disable iff (!rst_n)
        !(d_pmem_read && d_pmem_write))
        else $warning("pmem_arbiter: d_pmem_read and d_pmem_write both high, treated as write");

endmodule
